// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the slice-serial ALU sequencer.
package alu_seq_pkg;

    localparam int SLICE_W = 4;
    localparam int ALUOP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_seq_state_t;

    // Slice index width; a single-slice build still keeps a 1-bit index.
    function automatic int sidx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/response handshake plus the 4-bit datapath bus of the slice sequencer.
// Optional rsp_zero is present when ALU_ZERO_FLAG_EN is defined.
interface alu_slice_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               req_c_in;
    logic [ALUOP_W-1:0] req_aluop;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_c_out;
`ifdef ALU_ZERO_FLAG_EN
    logic               rsp_zero;
`endif

    logic [SLICE_W-1:0] alu_a;
    logic [SLICE_W-1:0] alu_b;
    logic               alu_c_in;
    logic [ALUOP_W-1:0] alu_op;
    logic [SLICE_W-1:0] alu_result;
    logic               alu_c_out;

    // Requester and external cla_4_bit side
    modport master (
`ifdef ALU_ZERO_FLAG_EN
        input  rsp_zero,
`endif
        output req_valid, req_a, req_b, req_c_in, req_aluop,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_c_out,
        output rsp_ready,
        input  alu_a, alu_b, alu_c_in, alu_op,
        output alu_result, alu_c_out
    );

    // Sequencer side
    modport slave (
`ifdef ALU_ZERO_FLAG_EN
        output rsp_zero,
`endif
        input  req_valid, req_a, req_b, req_c_in, req_aluop,
        output req_ready,
        output rsp_valid, rsp_result, rsp_c_out,
        input  rsp_ready,
        output alu_a, alu_b, alu_c_in, alu_op,
        input  alu_result, alu_c_out
    );

endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs WIDTH-bit ALU ops through an external 4-bit cla_4_bit, one slice per cycle, LSB first.
// Define ALU_ZERO_FLAG_EN to add the rsp_zero result flag.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    alu_slice_sequencer_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int SIDX_W = sidx_width(NSLICE);
    localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NSLICE - 1);

    alu_seq_state_t     state_reg;
    alu_seq_state_t     state_next;
    logic [SIDX_W-1:0]  slice_idx_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [ALUOP_W-1:0] op_reg;
    logic               carry_reg;
    logic               c_out_reg;

    logic               accept;
    logic               capture;
    logic               last_slice;
    logic [SLICE_W-1:0] a_slice [NSLICE];
    logic [SLICE_W-1:0] b_slice [NSLICE];
    logic [NSLICE-1:0]  slice_we;

    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign capture    = (state_reg == RUN);
    assign last_slice = (slice_idx_reg == LAST_IDX);

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign a_slice[gi]  = a_reg[SLICE_W*gi +: SLICE_W];
        assign b_slice[gi]  = b_reg[SLICE_W*gi +: SLICE_W];
        assign slice_we[gi] = capture && (slice_idx_reg == SIDX_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req_valid)              state_next = RUN;
            RUN:     if (last_slice)                 state_next = DONE;
            DONE:    if (bus.rsp_ready)              state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // req_ready is held low while reset is asserted so every output reads 0 in reset.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_c_in  = 1'b0;
        case (state_reg)
            IDLE: bus.req_ready = ~rst;
            RUN: begin
                bus.alu_a    = a_slice[slice_idx_reg];
                bus.alu_b    = b_slice[slice_idx_reg];
                bus.alu_c_in = carry_reg;
            end
            DONE:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_result = result_reg;
    assign bus.rsp_c_out  = c_out_reg;
    assign bus.alu_op     = op_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_idx_reg <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            carry_reg     <= 1'b0;
            c_out_reg     <= 1'b0;
        end else if (accept) begin
            slice_idx_reg <= '0;
            a_reg         <= bus.req_a;
            b_reg         <= bus.req_b;
            op_reg        <= bus.req_aluop;
            carry_reg     <= bus.req_c_in;
        end else if (capture) begin
            carry_reg <= bus.alu_c_out;
            if (last_slice) begin
                slice_idx_reg <= '0;
                c_out_reg     <= bus.alu_c_out;
            end else begin
                slice_idx_reg <= slice_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
        end else begin
            for (int i = 0; i < NSLICE; i++) begin
                if (slice_we[i]) begin
                    result_reg[SLICE_W*i +: SLICE_W] <= bus.alu_result;
                end
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic nonzero_reg;

    // Sticky across slices; only meaningful once the whole result is assembled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nonzero_reg <= 1'b0;
        end else if (accept) begin
            nonzero_reg <= 1'b0;
        end else if (capture) begin
            nonzero_reg <= nonzero_reg | (|bus.alu_result);
        end
    end

    assign bus.rsp_zero = (state_reg == DONE) & ~nonzero_reg;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer (WIDTH=16 and WIDTH=4) with a behavioural cla_4_bit.
// Zero-flag vectors run when ALU_ZERO_FLAG_EN is defined.
module tb_alu_slice_sequencer;

    logic clk;
    logic rst;

    int n_vectors;
    int n_miscompares;

    alu_slice_sequencer_if #(.WIDTH(16)) bus ();
    alu_slice_sequencer_if #(.WIDTH(4))  bus4 ();

    alu_slice_sequencer #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_slice_sequencer #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // External cla_4_bit stand-in: {c_out,result} = a + b + c_in regardless of op
    assign {bus.alu_c_out, bus.alu_result}   = 5'(bus.alu_a) + 5'(bus.alu_b) + 5'(bus.alu_c_in);
    assign {bus4.alu_c_out, bus4.alu_result} = 5'(bus4.alu_a) + 5'(bus4.alu_b) + 5'(bus4.alu_c_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [2:0] op, input logic [3:0] exp_carries,
                          input logic [15:0] exp_res, input logic exp_cout,
                          input bit scramble, input int hold);
        int cnt;
        bit seen;
        check_val("req_ready_idle", bus.req_ready, 1);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_c_in  = cin;
        bus.req_aluop = op;
        bus.req_valid = 1'b1;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            cnt++;
            if (bus.rsp_valid) begin
                seen = 1;
            end else if (cnt <= 4) begin
                check_val("run_req_ready", bus.req_ready, 0);
                check_val("alu_a", bus.alu_a, a[4*(cnt-1) +: 4]);
                check_val("alu_b", bus.alu_b, b[4*(cnt-1) +: 4]);
                check_val("alu_c_in", bus.alu_c_in, exp_carries[cnt-1]);
                check_val("alu_op", bus.alu_op, op);
                if (scramble) begin
                    bus.req_a     = 16'($urandom);
                    bus.req_b     = 16'($urandom);
                    bus.req_aluop = ~op;
                    bus.req_c_in  = ~cin;
                end
            end
        end
        check_val("rsp_seen", seen, 1);
        check_val("latency", cnt - 1, 4);
        check_val("rsp_result", bus.rsp_result, exp_res);
        check_val("rsp_c_out", bus.rsp_c_out, exp_cout);
        check_val("done_req_ready", bus.req_ready, 0);
        check_val("done_alu_a", bus.alu_a, 0);
        check_val("done_alu_c_in", bus.alu_c_in, 0);
`ifdef ALU_ZERO_FLAG_EN
        check_val("rsp_zero", bus.rsp_zero, (exp_res == 16'h0000));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_rsp_valid", bus.rsp_valid, 1);
            check_val("hold_req_ready", bus.req_ready, 0);
            check_val("hold_rsp_result", bus.rsp_result, exp_res);
            check_val("hold_rsp_c_out", bus.rsp_c_out, exp_cout);
        end
        // A request alongside the response handshake must not be taken.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check_val("post_req_ready", bus.req_ready, 1);
        check_val("post_rsp_valid", bus.rsp_valid, 0);
        $display("op a=0x%04h b=0x%04h cin=%0d -> result=0x%04h c_out=%0d",
                 a, b, cin, bus.rsp_result, bus.rsp_c_out);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_c_in   = 1'b0;
        bus.req_aluop  = '0;
        bus.rsp_ready  = 1'b0;
        bus4.req_valid = 1'b0;
        bus4.req_a     = '0;
        bus4.req_b     = '0;
        bus4.req_c_in  = 1'b0;
        bus4.req_aluop = '0;
        bus4.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_req_ready", bus.req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_req_ready", bus.req_ready, 1);
        check_val("reset_rsp_valid", bus.rsp_valid, 0);
        check_val("reset_rsp_result", bus.rsp_result, 0);
        check_val("reset_rsp_c_out", bus.rsp_c_out, 0);
        check_val("reset_alu_op", bus.alu_op, 0);
        check_val("reset_alu_a", bus.alu_a, 0);

        // Full carry ripple through every slice
        run_op(16'hFFFF, 16'h0001, 1'b0, 3'd2, 4'b1110, 16'h0000, 1'b1, 0, 0);

        // Consumer stalls for three DONE cycles
        run_op(16'h1234, 16'h0FFF, 1'b0, 3'd1, 4'b1110, 16'h2233, 1'b0, 0, 3);

        // Abort with async reset after two slices
        bus.req_a     = 16'hABCD;
        bus.req_b     = 16'h1111;
        bus.req_c_in  = 1'b1;
        bus.req_aluop = 3'd5;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("pre_rst_alu_a", bus.alu_a, 4'hB);
        check_val("pre_rst_alu_op", bus.alu_op, 5);
        rst = 1'b1;
        #1;
        check_val("arst_req_ready", bus.req_ready, 0);
        check_val("arst_rsp_valid", bus.rsp_valid, 0);
        check_val("arst_rsp_result", bus.rsp_result, 0);
        check_val("arst_rsp_c_out", bus.rsp_c_out, 0);
        check_val("arst_alu_a", bus.alu_a, 0);
        check_val("arst_alu_b", bus.alu_b, 0);
        check_val("arst_alu_c_in", bus.alu_c_in, 0);
        check_val("arst_alu_op", bus.alu_op, 0);
        $display("async reset during RUN applied");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0005, 16'h0003, 1'b0, 3'd0, 4'b0000, 16'h0008, 1'b0, 0, 0);

        // Request fields wiggle during RUN and must be ignored
        run_op(16'h00F0, 16'h0F10, 1'b1, 3'b110, 4'b1101, 16'h1001, 1'b0, 1, 1);
        check_val("op_kept_idle", bus.alu_op, 3'b110);

`ifdef ALU_ZERO_FLAG_EN
        run_op(16'h8000, 16'h8000, 1'b0, 3'd0, 4'b0000, 16'h0000, 1'b1, 0, 0);
        run_op(16'h0010, 16'h0000, 1'b0, 3'd0, 4'b0000, 16'h0010, 1'b0, 0, 0);
`endif

        // Single-slice build: one RUN cycle
        check_val("w4_req_ready", bus4.req_ready, 1);
        bus4.req_a     = 4'h9;
        bus4.req_b     = 4'h9;
        bus4.req_c_in  = 1'b1;
        bus4.req_aluop = 3'd3;
        bus4.req_valid = 1'b1;
        @(negedge clk);
        bus4.req_valid = 1'b0;
        check_val("w4_alu_a", bus4.alu_a, 4'h9);
        check_val("w4_alu_c_in", bus4.alu_c_in, 1);
        check_val("w4_alu_op", bus4.alu_op, 3);
        check_val("w4_rsp_valid_run", bus4.rsp_valid, 0);
        @(negedge clk);
        check_val("w4_rsp_valid", bus4.rsp_valid, 1);
        check_val("w4_rsp_result", bus4.rsp_result, 4'h3);
        check_val("w4_rsp_c_out", bus4.rsp_c_out, 1);
        bus4.rsp_ready = 1'b1;
        @(negedge clk);
        bus4.rsp_ready = 1'b0;
        check_val("w4_post_req_ready", bus4.req_ready, 1);
        $display("op width4 a=0x9 b=0x9 cin=1 -> result=0x%0h c_out=%0d",
                 bus4.rsp_result, bus4.rsp_c_out);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
